// File: rtl/bus_datapath.sv
// Multi-cycle register-file datapath: a one-hot bus multiplexer feeds R[], A and G under a T1..T3 FSM.
// Optional feature: define DP_SUB_EN to enable opcode 4 (SUB); otherwise opcode 4 is rejected as illegal.
module bus_datapath #(
    parameter int DATA_W  = 8,
    parameter int REG_NUM = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [3:0]                 instr_op,
    input  logic [$clog2(REG_NUM)-1:0] instr_rx,
    input  logic [$clog2(REG_NUM)-1:0] instr_ry,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       done,
    output logic                       err,
    output logic [DATA_W-1:0]          result,
    output logic                       carry,
    output logic                       zero,
    output logic [DATA_W-1:0]          bus_mon
);

    localparam int REG_AW = $clog2(REG_NUM);

    localparam logic [3:0] OP_LOAD = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
`ifdef DP_SUB_EN
    localparam logic [3:0] OP_SUB  = 4'd4;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_next;

    logic [3:0]        op_q;
    logic [REG_AW-1:0] rx_q;
    logic [REG_AW-1:0] ry_q;

    logic [DATA_W-1:0] regs [REG_NUM];
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] g_reg;
    logic              carry_flag;
    logic              zero_flag;

    logic [DATA_W-1:0]  bus;
    logic [DATA_W:0]    alu_res;
    logic               sel_data;
    logic               sel_g;
    logic [REG_NUM-1:0] sel_reg;
    logic               r_we;
    logic               a_we;
    logic               g_we;

    function automatic logic op_is_alu(input logic [3:0] op);
        logic r;
        case (op)
            OP_ADD, OP_XOR: r = 1'b1;
`ifdef DP_SUB_EN
            OP_SUB:         r = 1'b1;
`endif
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_MOV) || op_is_alu(op);
    endfunction

    // MSB of the (DATA_W+1)-bit result is carry-out for ADD and borrow for SUB.
    function automatic logic [DATA_W:0] alu_calc(input logic [3:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_XOR:  r = {1'b0, a ^ b};
`ifdef DP_SUB_EN
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    state_next = op_is_legal(instr_op) ? T1 : DONE;
                end
            end
            T1:      state_next = op_is_alu(op_q) ? T2 : DONE;
            T2:      state_next = T3;
            T3:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_data = 1'b0;
        sel_g    = 1'b0;
        sel_reg  = '0;
        r_we     = 1'b0;
        a_we     = 1'b0;
        g_we     = 1'b0;
        case (state)
            T1: begin
                if (op_q == OP_LOAD) begin
                    sel_data = 1'b1;
                    r_we     = 1'b1;
                end else if (op_q == OP_MOV) begin
                    sel_reg[ry_q] = 1'b1;
                    r_we          = 1'b1;
                end else begin
                    sel_reg[rx_q] = 1'b1;
                    a_we          = 1'b1;
                end
            end
            T2: begin
                sel_reg[ry_q] = 1'b1;
                g_we          = 1'b1;
            end
            T3: begin
                sel_g = 1'b1;
                r_we  = 1'b1;
            end
            default: ;
        endcase
    end

    // AND-OR bus: selects are one-hot, so an idle bus reads as zero.
    always_comb begin
        bus = '0;
        if (sel_data) begin
            bus = bus | data_in;
        end
        for (int i = 0; i < REG_NUM; i++) begin
            if (sel_reg[i]) begin
                bus = bus | regs[i];
            end
        end
        if (sel_g) begin
            bus = bus | g_reg;
        end
    end

    always_comb begin
        alu_res = alu_calc(op_q, a_reg, bus);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            rx_q <= '0;
            ry_q <= '0;
        end else if (state == IDLE && instr_valid) begin
            op_q <= instr_op;
            rx_q <= instr_rx;
            ry_q <= instr_ry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
            a_reg      <= '0;
            g_reg      <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            if (r_we) begin
                regs[rx_q] <= bus;
            end
            if (a_we) begin
                a_reg <= bus;
            end
            if (g_we) begin
                g_reg      <= alu_res[DATA_W-1:0];
                carry_flag <= alu_res[DATA_W];
                zero_flag  <= (alu_res[DATA_W-1:0] == '0);
            end
        end
    end

    assign instr_ready = (state == IDLE);
    assign done        = (state == DONE);
    assign err         = (state == DONE) && !op_is_legal(op_q);
    assign result      = g_reg;
    assign carry       = carry_flag;
    assign zero        = zero_flag;
    assign bus_mon     = bus;

endmodule

// File: tb/tb_bus_datapath.sv
// Directed bench for bus_datapath: latency, ALU results/flags, illegal ops, reset abort, back-to-back valid.
module tb_bus_datapath;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [2:0] instr_rx;
    logic [2:0] instr_ry;
    logic [7:0] data_in;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic [7:0] bus_mon;

    int checks = 0;
    int errors = 0;
    int lat;

    bus_datapath #(.DATA_W(8), .REG_NUM(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rx    (instr_rx),
        .instr_ry    (instr_ry),
        .data_in     (data_in),
        .done        (done),
        .err         (err),
        .result      (result),
        .carry       (carry),
        .zero        (zero),
        .bus_mon     (bus_mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one instruction in an IDLE cycle; return at the negedge where done is seen.
    task automatic run(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry,
                       input logic [7:0] d, input int exp_lat, input logic exp_err, input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, instr_ready, 1'b1);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rx    = rx;
        instr_ry    = ry;
        data_in     = d;
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_err"}, err, exp_err);
    endtask

    logic [4:0] rdy_seen;
    logic [4:0] done_seen;
    logic [7:0] bus_seen [5];

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_op    = 4'd0;
        instr_rx    = 3'd0;
        instr_ry    = 3'd0;
        data_in     = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_carry", carry, 1'b0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_bus", bus_mon, 8'h00);

        // LOAD / MOV / ADD basic flow
        run(4'd0, 3'd1, 3'd0, 8'h05, 2, 1'b0, "load_r1");
        chk("load_r1_val", dut.regs[1], 8'h05);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        run(4'd1, 3'd0, 3'd1, 8'hEE, 2, 1'b0, "mov_r0_r1");
        chk("mov_r0_val", dut.regs[0], 8'h05);
        run(4'd2, 3'd0, 3'd1, 8'h00, 4, 1'b0, "add_r0_r1");
        chk("add1_result", result, 8'h0A);
        chk("add1_carry", carry, 1'b0);
        chk("add1_r0", dut.regs[0], 8'h0A);

        // ADD with carry-out
        run(4'd0, 3'd1, 3'd0, 8'hF0, 2, 1'b0, "load_f0");
        run(4'd0, 3'd2, 3'd0, 8'h20, 2, 1'b0, "load_20");
        run(4'd2, 3'd1, 3'd2, 8'h00, 4, 1'b0, "add_carry");
        chk("add2_result", result, 8'h10);
        chk("add2_carry", carry, 1'b1);
        chk("add2_zero", zero, 1'b0);
        chk("add2_r1", dut.regs[1], 8'h10);
        chk("add2_r2", dut.regs[2], 8'h20);

        // rx == ry doubles the pre-instruction value
        run(4'd0, 3'd4, 3'd0, 8'h41, 2, 1'b0, "load_41");
        run(4'd2, 3'd4, 3'd4, 8'h00, 4, 1'b0, "add_double");
        chk("dbl_result", result, 8'h82);
        chk("dbl_carry", carry, 1'b0);
        chk("dbl_r4", dut.regs[4], 8'h82);

        // XOR with itself -> zero
        run(4'd0, 3'd3, 3'd0, 8'h5A, 2, 1'b0, "load_5a");
        run(4'd3, 3'd3, 3'd3, 8'h00, 4, 1'b0, "xor_self");
        chk("xor_result", result, 8'h00);
        chk("xor_zero", zero, 1'b1);
        chk("xor_carry", carry, 1'b0);
        chk("xor_r3", dut.regs[3], 8'h00);

        // SUB: borrow when enabled, illegal otherwise
        run(4'd0, 3'd1, 3'd0, 8'h03, 2, 1'b0, "load_03");
        run(4'd0, 3'd2, 3'd0, 8'h05, 2, 1'b0, "load_05");
`ifdef DP_SUB_EN
        run(4'd4, 3'd1, 3'd2, 8'h00, 4, 1'b0, "sub");
        chk("sub_result", result, 8'hFE);
        chk("sub_carry", carry, 1'b1);
        chk("sub_zero", zero, 1'b0);
        chk("sub_r1", dut.regs[1], 8'hFE);
`else
        run(4'd4, 3'd1, 3'd2, 8'h00, 1, 1'b1, "sub_off");
        chk("sub_off_result", result, 8'h00);
        chk("sub_off_carry", carry, 1'b0);
        chk("sub_off_zero", zero, 1'b1);
        chk("sub_off_r1", dut.regs[1], 8'h03);
`endif

        // Illegal opcode leaves state untouched
        run(4'd15, 3'd2, 3'd2, 8'h00, 1, 1'b1, "illegal");
        chk("ill_r2", dut.regs[2], 8'h05);
        @(negedge clk);
        chk("ill_err_clears", err, 1'b0);

        // Reset during T2 of an ADD
        run(4'd0, 3'd5, 3'd0, 8'h11, 2, 1'b0, "load_11");
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 4'd2;
        instr_rx    = 3'd5;
        instr_ry    = 3'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("t2_busy", instr_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", instr_ready, 1'b1);
        chk("abort_done", done, 1'b0);
        chk("abort_result", result, 8'h00);
        chk("abort_flags", {carry, zero}, 2'b00);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("abort_r%0d", i), dut.regs[i], 8'h00);
        end

        // instr_valid held high: accepted only in IDLE cycles
        instr_valid = 1'b1;
        instr_op    = 4'd0;
        instr_rx    = 3'd1;
        instr_ry    = 3'd0;
        data_in     = 8'h07;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rdy_seen[i]  = instr_ready;
            done_seen[i] = done;
            bus_seen[i]  = bus_mon;
        end
        instr_valid = 1'b0;
        chk("hold_ready", rdy_seen, 5'b00100);
        chk("hold_done", done_seen, 5'b10010);
        chk("hold_bus_t1", bus_seen[0], 8'h07);
        chk("hold_bus_done", bus_seen[1], 8'h00);
        chk("hold_r1", dut.regs[1], 8'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
